// File: rtl/fifo_arb_pkg.sv
// Shared constants and state encoding for the FIFO write-port arbiter.
// The FIFO_ARB_WORD_CNT_EN build option is handled in fifo_wr_arbiter.
package fifo_arb_pkg;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_BURST_MAX = 4;

  typedef logic [0:0] arb_state_t;

  localparam arb_state_t ARB_IDLE  = 1'b0;
  localparam arb_state_t ARB_GRANT = 1'b1;

  // A single-word burst still needs a 1-bit counter.
  function automatic int burst_cnt_w(input int burst_max);
    return (burst_max > 1) ? $clog2(burst_max) : 1;
  endfunction

  localparam int BURST_CNT_W = burst_cnt_w(DEF_BURST_MAX);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set mask bit strictly after ptr,
// wrapping, so the requester at ptr itself is considered last.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int               pos;
  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the search so no latch is inferred.
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    pos    = 0;
    cand   = '0;
    for (int k = 1; k <= N; k++) begin
      pos  = (int'(ptr) + k) % N;
      cand = IDX_W'(pos);
      if (!valid && mask[cand]) begin
        valid        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among N_REQ requesters.
// Define FIFO_ARB_WORD_CNT_EN to add the saturating WORD_CNT output.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int BURST_MAX = DEF_BURST_MAX,
  parameter int CNT_W     = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*WIDTH-1:0] REQ_DATA,
  input  logic [N_REQ-1:0]       REQ_LAST,
  input  logic                   FULL_FLAG,
  output logic [N_REQ-1:0]       GNT,
  output logic                   WR_EN,
  output logic [WIDTH-1:0]       DATA_IN,
  output logic                   BUSY
`ifdef FIFO_ARB_WORD_CNT_EN
  ,
  output logic [CNT_W-1:0]       WORD_CNT
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BCW   = burst_cnt_w(BURST_MAX);

  localparam logic [BCW-1:0]   CNT_LAST = BCW'(BURST_MAX - 1);
  localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(N_REQ - 1);

  arb_state_t       state;
  logic [IDX_W-1:0] own;
  logic [IDX_W-1:0] ptr;
  logic [BCW-1:0]   cnt;

  logic             granted;
  logic             acc;
  logic             burst_end;
  logic             owner_gone;
  logic             rel;
  logic [N_REQ-1:0] pick_mask;
  logic [IDX_W-1:0] pick_ptr;
  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;

  always_comb begin
    granted    = (state == ARB_GRANT);
    acc        = granted & REQ[own] & GNT[own] & ~FULL_FLAG & ~RST;
    burst_end  = acc & (REQ_LAST[own] | (cnt == CNT_LAST));
    owner_gone = granted & ~REQ[own];
    rel        = burst_end | owner_gone;
    // On release the owner is masked out and the search restarts just after it.
    pick_mask  = granted ? (REQ & ~GNT) : REQ;
    pick_ptr   = granted ? own : ptr;
  end

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .mask   (pick_mask),
    .ptr    (pick_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign WR_EN   = acc;
  assign DATA_IN = granted ? REQ_DATA[int'(own)*WIDTH +: WIDTH] : '0;
  assign BUSY    = granted;

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (RST) begin
      state <= ARB_IDLE;
      GNT   <= '0;
      own   <= '0;
      ptr   <= PTR_INIT;
      cnt   <= '0;
    end else if (state == ARB_IDLE) begin
      if (pick_valid) begin
        state <= ARB_GRANT;
        GNT   <= pick_onehot;
        own   <= pick_idx;
        cnt   <= '0;
      end
    end else if (rel) begin
      ptr <= own;
      cnt <= '0;
      if (pick_valid) begin
        GNT <= pick_onehot;
        own <= pick_idx;
      end else begin
        state <= ARB_IDLE;
        GNT   <= '0;
      end
    end else if (acc) begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef FIFO_ARB_WORD_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      WORD_CNT <= '0;
    end else if (acc && (WORD_CNT != '1)) begin
      WORD_CNT <= WORD_CNT + 1'b1;
    end
  end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares the single write port of the async FIFO (DATA_IN / WR_EN / FULL_FLAG) between N_REQ requesters.
- Sits entirely in the CLK_WRITE domain, in front of the FIFO write side.
- Grants one requester at a time for a burst of up to BURST_MAX words; a burst ends early on REQ_LAST.
- Respects FULL_FLAG so no word is ever presented while the FIFO is full.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, data width; matches FIFO WIDTH.
- BURST_MAX, 4, maximum accepted words per grant (>=1).
- CNT_W, 16, width of the optional word counter.

Ports:
- CLK  in  1  write-domain clock (FIFO CLK_WRITE).
- RST  in  1  synchronous, active-high reset.
- REQ  in  N_REQ  requester i holds a valid word.
- REQ_DATA  in  N_REQ*WIDTH  flattened data; requester i drives bits [i*WIDTH +: WIDTH].
- REQ_LAST  in  N_REQ  current word of requester i is the last of its burst.
- FULL_FLAG  in  1  FIFO full flag.
- GNT  out  N_REQ  registered one-hot grant; also serves as the requester's ready.
- WR_EN  out  1  FIFO write enable.
- DATA_IN  out  WIDTH  FIFO write data.
- BUSY  out  1  a grant is active.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - GNT=0, BUSY=0, burst count=0.
  - Round-robin pointer = N_REQ-1, so requester 0 has top priority first.
  - WR_EN=0 while RST is high.
- FSM states:
  - ARB_IDLE: GNT=0.
  - ARB_GRANT: GNT one-hot equals the owner.
- Accept (combinational): acc = REQ[own] & GNT[own] & ~FULL_FLAG & ~RST.
  - WR_EN = acc.
  - DATA_IN = REQ_DATA slice of the owner when granted, else 0.
  - Requester i advances its word on a cycle where REQ[i] & GNT[i] & ~FULL_FLAG.
- ARB_IDLE -> ARB_GRANT:
  - If any REQ is set, pick the first set bit searching from ptr+1 upward, with wrap.
  - GNT is registered, so there is 1 cycle from REQ to GNT; burst count=0.
- Release conditions in ARB_GRANT:
  - (a) acc & REQ_LAST[own];
  - (b) acc & count==BURST_MAX-1;
  - (c) REQ[own]==0, with no write that cycle.
- On an accept that is not a release: count increments.
- On release:
  - ptr <= own.
  - Re-arbitrate in the same cycle over REQ, excluding the owner when cases (a)/(b) apply; REQ[own] is already 0 in case (c).
  - If a winner exists, GNT switches directly to it on the next edge: back-to-back bursts, no bubble, count=0.
  - Otherwise -> ARB_IDLE.
- Only the sole requester: after release it is re-granted through ARB_IDLE, giving a 1 bubble cycle.
- FULL_FLAG high: no accept, GNT held, count frozen, no timeout; resume on deassert.
- BUSY = (state==ARB_GRANT).
- REQ of a non-owner has no effect until the next arbitration.
- RST mid-burst: grant dropped at that edge and pending words are not written; requester data is untouched.

Optional Feature:
- Macro: FIFO_ARB_WORD_CNT_EN.
- Defined: adds output WORD_CNT [CNT_W-1:0].
  - Counts accepted words (WR_EN cycles).
  - Saturates at all-ones.
  - Reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package fifo_arb_pkg:
  - state typedef {ARB_IDLE, ARB_GRANT};
  - burst-count width constant clog2(BURST_MAX);
  - default N_REQ/WIDTH constants.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: request mask, pointer.
  - Outputs: one-hot winner, index, valid.
  - Instantiated once in fifo_wr_arbiter.

Test Plan:
- Reset: RST=1 for 2 cycles with REQ=4'b1111 -> GNT=0, WR_EN=0, BUSY=0; after release, first GNT=4'b0001.
- Single burst: REQ=4'b0010 with words A1,A2,A3, LAST on A3, cycle 0 -> GNT=4'b0010 at cycle 1; WR_EN in cycles 1-3 with DATA_IN=A1,A2,A3; GNT=0 at cycle 4.
- Fairness: REQ=4'b1111 held, no LAST, BURST_MAX=4 -> grant order 0,1,2,3,0, each exactly 4 consecutive WR_EN cycles, no gap between bursts.
- Backpressure: FULL_FLAG=1 for 5 cycles after the 2nd word of a burst -> WR_EN=0 and GNT held during those cycles; words 3-4 written afterwards; total 4 words.
- Owner drop: owner 2 drops REQ after 2 words while REQ[3]=1 -> GNT=4'b1000 on the next edge; no spurious WR_EN.
- Mid-burst reset with FIFO_ARB_WORD_CNT_EN defined: RST after 3 words -> GNT=0, WORD_CNT=0; REQ=4'b1010 afterwards -> requester 1 granted first; WORD_CNT increments once per WR_EN.
